pc_sequencer: RTL

- Control stage directly upstream of the program counter in the BIP-I core.
- Decides each cycle whether the PC advances and supplies the next PC value (current PC + 1) on the PC's enable and new-value inputs.
- Sequences execution: idle after reset, free-run or single-step on commands from the UART debug unit, and stops permanently on the HLT opcode.
- Keeps an executed-instruction counter that the debug unit reports after halt.

---
 rtl/pc_sequencer.sv | 74 +++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// BIP-I PC sequencer: decides when the PC advances (loaded on the falling edge),
// sequences idle/run/step/halt from debug-unit commands and counts executed instructions.
module pc_sequencer #(
   parameter int                PCLEN      = 11,
   parameter int                OPLEN      = 5,
   parameter int                CNTLEN     = 32,
   parameter logic [OPLEN-1:0]  HLT_OPCODE = '0
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   input  logic              i_step,
   input  logic [OPLEN-1:0]  i_opcode,
   input  logic [PCLEN-1:0]  i_PCval,
   output logic              o_pc_en,
   output logic [PCLEN-1:0]  o_newPCval,
   output logic              o_running,
   output logic              o_halted,
   output logic              o_done,
   output logic [CNTLEN-1:0] o_cycles
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_STEP, S_HALT} state_t;

   state_t state, state_nx;
   logic   is_hlt, exec;

   always_ff @(posedge i_clk) begin
      if (i_rst) state <= S_IDLE;
      else       state <= state_nx;
   end

   // Outputs are purely combinational so the PC sees them well before its falling-edge load.
   always_comb begin
      state_nx   = state;
      is_hlt     = (i_opcode == HLT_OPCODE);
      exec       = 1'b0;
      o_running  = 1'b0;
      o_halted   = 1'b0;
      o_newPCval = i_PCval + PCLEN'(1);
      case (state)
         S_IDLE: begin
            if (i_start)     state_nx = S_RUN;
            else if (i_step) state_nx = S_STEP;
         end
         S_RUN: begin
            o_running = 1'b1;
            exec      = !is_hlt;
            if (is_hlt) state_nx = S_HALT;
         end
         S_STEP: begin
            exec     = !is_hlt;
            state_nx = is_hlt ? S_HALT : S_IDLE;
         end
         S_HALT: begin
            o_halted = 1'b1;
         end
         default: state_nx = S_IDLE;
      endcase
      o_pc_en = exec;
   end

   // Counter saturates instead of wrapping; HLT itself never sets exec so is not counted.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_cycles <= '0;
         o_done   <= 1'b0;
      end else begin
         if (exec && (o_cycles != '1)) o_cycles <= o_cycles + CNTLEN'(1);
         o_done <= (state != S_HALT) && (state_nx == S_HALT);
      end
   end

endmodule
